// File: rtl/fw_loader_pkg.sv
// rtl/fw_loader_pkg.sv - shared types and constants for the firmware boot loader
package fw_loader_pkg;

    // Frame parser states; ST_ prefix keeps them apart from the MAGIC parameter
    typedef enum logic [2:0] {
        ST_MAGIC   = 3'd0,
        ST_LENGTH  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_MAGIC = 2'd1,
        ERR_LEN   = 2'd2,
        ERR_CHK   = 2'd3
    } err_t;

    localparam logic [31:0] DEFAULT_MAGIC = 32'h4D4F5250;

endpackage

// File: rtl/fw_loader_if.sv
// rtl/fw_loader_if.sv - image stream input and instruction-memory write port
interface fw_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    // Image source and memory side
    modport master (
        output s_valid, s_data,
        input  s_ready, mem_we, mem_addr, mem_wdata
    );

    // Loader side
    modport slave (
        input  s_valid, s_data,
        output s_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fw_loader.sv
// rtl/fw_loader.sv - framed image loader writing instruction memory and gating cpu reset
module fw_loader
    import fw_loader_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter logic [DATA_WIDTH-1:0] MAGIC      = DATA_WIDTH'(DEFAULT_MAGIC)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    fw_loader_if.slave  bus,
    output logic        cpu_reset_n,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);

    // Compare width must hold both a full stream word and the depth 2**ADDR_WIDTH
    localparam int             CW    = (DATA_WIDTH > ADDR_WIDTH) ? DATA_WIDTH : ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  DEPTH = CW'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    err_t                  err_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   idx_q;
    logic [ADDR_WIDTH:0]   idx_inc;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [CW-1:0]         len_ext;
    logic                  hs;
    logic                  magic_ok;
    logic                  len_over;
    logic                  len_zero;
    logic                  chk_ok;

    assign hs       = bus.s_valid && bus.s_ready;
    assign len_ext  = CW'(bus.s_data);
    assign magic_ok = (bus.s_data == MAGIC);
    assign len_over = (len_ext > DEPTH);
    assign len_zero = (len_ext == '0);
    assign chk_ok   = (bus.s_data == acc_q);
    assign idx_inc  = idx_q + (ADDR_WIDTH + 1)'(1);
    assign err_code = err_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_MAGIC;
        else       state_q <= state_d;
    end

    // Next-state decode: advance on handshakes, DONE/ERROR wait for restart
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_MAGIC:   if (hs) state_d = magic_ok ? ST_LENGTH : ST_ERROR;
            ST_LENGTH:  if (hs) state_d = len_over ? ST_ERROR : (len_zero ? ST_CHECK : ST_PAYLOAD);
            ST_PAYLOAD: if (hs && (idx_inc == len_q)) state_d = ST_CHECK;
            ST_CHECK:   if (hs) state_d = chk_ok ? ST_DONE : ST_ERROR;
            ST_DONE:    if (restart) state_d = ST_MAGIC;
            ST_ERROR:   if (restart) state_d = ST_MAGIC;
            default:    state_d = ST_MAGIC;
        endcase
    end

    // Status outputs are pure functions of state
    always_comb begin
        bus.s_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cpu_reset_n = 1'b0;
        case (state_q)
            ST_MAGIC, ST_LENGTH, ST_PAYLOAD, ST_CHECK: begin
                bus.s_ready = 1'b1;
                busy        = 1'b1;
            end
            ST_DONE: begin
                done        = 1'b1;
                cpu_reset_n = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: length/index/checksum tracking, registered memory write, sticky error code
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q         <= '0;
            idx_q         <= '0;
            acc_q         <= '0;
            err_q         <= ERR_NONE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state_q)
                ST_MAGIC: begin
                    if (hs && !magic_ok) err_q <= ERR_MAGIC;
                end
                ST_LENGTH: begin
                    if (hs) begin
                        len_q <= len_ext[ADDR_WIDTH:0];
                        idx_q <= '0;
                        acc_q <= '0;
                        if (len_over) err_q <= ERR_LEN;
                    end
                end
                ST_PAYLOAD: begin
                    if (hs) begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= idx_q[ADDR_WIDTH-1:0];
                        bus.mem_wdata <= bus.s_data;
                        idx_q         <= idx_inc;
                        acc_q         <= acc_q ^ bus.s_data;
                    end
                end
                ST_CHECK: begin
                    if (hs && !chk_ok) err_q <= ERR_CHK;
                end
                ST_ERROR: begin
                    if (restart) err_q <= ERR_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fw_loader.sv
// tb/tb_fw_loader.sv - self-checking bench for fw_loader with a write scoreboard
module tb_fw_loader;
    import fw_loader_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [31:0] MAGIC_W = 32'h4D4F5250;

    typedef struct {
        logic [31:0] magic;
        int          len;
        int          nsend;
        logic [31:0] pl [16];
        logic [31:0] chkw;
        bit          calc_chk;
        bit          gaps;
        int          exp_err;
        bit          exp_done;
    } vec_t;

    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        restart = 1'b0;
    logic        cpu_reset_n;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    wr_t         exp_q [$];
    logic [31:0] tb_mem [16];
    vec_t        vecs [7];

    fw_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fw_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAGIC(MAGIC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .restart     (restart),
        .bus         (bus.slave),
        .cpu_reset_n (cpu_reset_n),
        .busy        (busy),
        .done        (done),
        .err_code    (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every observed write must match the oldest expected write, including its cycle
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("wr_data", bus.mem_wdata, e.data);
                chk("wr_cycle", 32'(cyc), 32'(e.cyc));
            end
            tb_mem[bus.mem_addr] = bus.mem_wdata;
        end
    end

    task automatic send_word(input logic [31:0] w, input bit push, input int addr, input bit gaps);
        int n;
        wr_t e;
        if (gaps) begin
            n = $urandom_range(0, 2);
            bus.s_valid = 1'b0;
            repeat (n) @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        n = 0;
        while (bus.s_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.s_ready !== 1'b1) chk("s_ready_timeout", 32'(bus.s_ready), 32'd1);
        if (push) begin
            e.cyc  = cyc + 1;
            e.addr = addr;
            e.data = w;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_vec(input int k, input logic [31:0] m, input int len, input int nsend,
                           input logic [31:0] chkw, input bit calc, input bit gaps,
                           input int err, input bit dn);
        vecs[k].magic    = m;
        vecs[k].len      = len;
        vecs[k].nsend    = nsend;
        vecs[k].chkw     = chkw;
        vecs[k].calc_chk = calc;
        vecs[k].gaps     = gaps;
        vecs[k].exp_err  = err;
        vecs[k].exp_done = dn;
        for (int i = 0; i < 16; i++) vecs[k].pl[i] = 32'h0;
    endtask

    task automatic do_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("restart_s_ready", 32'(bus.s_ready), 32'd1);
        chk("restart_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        chk("restart_err_code", 32'(err_code), 32'd0);
        chk("restart_done", 32'(done), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_s_ready"}, 32'(bus.s_ready), 32'd1);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] frame [$];
        logic [31:0] x;
        bit          need_restart;

        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        for (int i = 0; i < 16; i++) tb_mem[i] = 32'h0;

        set_vec(0, MAGIC_W, 3, 6, 32'h77, 0, 0, 0, 1);
        vecs[0].pl[0] = 32'h11; vecs[0].pl[1] = 32'h22; vecs[0].pl[2] = 32'h44;
        set_vec(1, 32'hDEADBEEF, 3, 1, 32'h0, 0, 0, 1, 0);
        set_vec(2, MAGIC_W, 16, 19, 32'h0, 1, 0, 0, 1);
        for (int i = 0; i < 16; i++) vecs[2].pl[i] = (32'h100 * (i + 1)) ^ 32'(i);
        set_vec(3, MAGIC_W, 17, 2, 32'h0, 0, 0, 2, 0);
        set_vec(4, MAGIC_W, 2, 5, 32'h0, 0, 0, 3, 0);
        vecs[4].pl[0] = 32'h1; vecs[4].pl[1] = 32'h2;
        set_vec(5, MAGIC_W, 0, 3, 32'h0, 0, 0, 0, 1);
        set_vec(6, MAGIC_W, 3, 6, 32'h77, 0, 1, 0, 1);
        vecs[6].pl[0] = 32'h11; vecs[6].pl[1] = 32'h22; vecs[6].pl[2] = 32'h44;

        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        need_restart = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (need_restart) do_restart();
            frame.delete();
            frame.push_back(vecs[k].magic);
            frame.push_back(32'(vecs[k].len));
            x = 32'h0;
            for (int i = 0; i < vecs[k].len && i < 16; i++) begin
                frame.push_back(vecs[k].pl[i]);
                x ^= vecs[k].pl[i];
            end
            frame.push_back(vecs[k].calc_chk ? x : vecs[k].chkw);

            for (int j = 0; j < vecs[k].nsend; j++) begin
                if (vecs[k].exp_done && j == vecs[k].nsend - 1)
                    chk("pre_chk_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
                send_word(frame[j], (j >= 2 && j < 2 + vecs[k].len), j - 2, vecs[k].gaps);
            end
            bus.s_valid = 1'b0;

            chk($sformatf("v%0d_err_code", k), 32'(err_code), 32'(vecs[k].exp_err));
            chk($sformatf("v%0d_done", k), 32'(done), 32'(vecs[k].exp_done));
            chk($sformatf("v%0d_cpu_reset_n", k), 32'(cpu_reset_n), 32'(vecs[k].exp_done));
            chk($sformatf("v%0d_s_ready", k), 32'(bus.s_ready), 32'd0);
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_pending_writes", k), 32'(exp_q.size()), 32'd0);
            if (vecs[k].exp_done)
                for (int i = 0; i < vecs[k].len; i++)
                    chk($sformatf("v%0d_mem%0d", k, i), tb_mem[i], vecs[k].pl[i]);
            need_restart = 1'b1;
        end

        do_restart();
        send_word(MAGIC_W, 0, 0, 0);
        send_word(32'd5, 0, 0, 0);
        send_word(32'hA0, 1, 0, 0);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hA1;
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check_reset_values("midreset");
        @(negedge clk);
        reset = 1'b0;
        bus.s_valid = 1'b0;
        chk("midreset_pending_writes", 32'(exp_q.size()), 32'd0);

        x = 32'h0;
        send_word(MAGIC_W, 0, 0, 0);
        send_word(32'd5, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            send_word(32'hB0 + 32'(i * 3), 1, i, 0);
            x ^= 32'hB0 + 32'(i * 3);
        end
        send_word(x, 0, 0, 0);
        bus.s_valid = 1'b0;
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_cpu_reset_n", 32'(cpu_reset_n), 32'd1);
        for (int i = 0; i < 5; i++)
            chk($sformatf("reload_mem%0d", i), tb_mem[i], 32'hB0 + 32'(i * 3));

        bus.s_valid = 1'b1;
        bus.s_data  = 32'h12345678;
        repeat (3) @(negedge clk);
        bus.s_valid = 1'b0;
        chk("done_ignores_valid_done", 32'(done), 32'd1);
        chk("done_ignores_valid_s_ready", 32'(bus.s_ready), 32'd0);
        chk("done_ignores_valid_err", 32'(err_code), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
